feature_fetcher: RTL and testbench

Streaming reader for the Haar classifier memories. Drives the existing `counter` block, which owns address generation and end detection, issues synchronous reads to a 1-cycle-latency memory, and presents the words as a valid/ready stream with a last-word flag. Sits between the classifier ROMs and the feature evaluation stage, and sustains one word per clock when the sink is always ready.

---
 rtl/haar_pkg.sv | 6 +
 rtl/skid_fifo2.sv | 30 +++
 rtl/feature_fetcher.sv | 70 +++++++
 tb/tb_feature_fetcher.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
// haar_pkg: shared state encoding and default widths for the Haar memory readers
package haar_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO holding {last, data}; caller never pushes when full or pops when empty
module skid_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/feature_fetcher.sv
// feature_fetcher: streams one classifier-memory pass via the external counter
// into a valid/ready interface with a last-word flag.
module feature_fetcher
  import haar_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  o_counter_clear,
  output logic                  o_trigger_compare,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_is_end_reached,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_address,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);
  state_t state, state_nxt;
  logic issued_all, inflight, inflight_last, issue, hs;
  logic [1:0] count;
  assign o_valid = count != 2'd0;
  assign hs = o_valid & i_ready;
  // a word popped this cycle frees its slot in time for the read issued now
  assign issue = state == RUN && !issued_all && ({1'b0, count} + 3'(inflight) - 3'(hs)) < 3'd2;
  assign o_rd_en = issue;
  assign o_rd_address = issue ? i_address : '0;
  assign o_trigger_compare = issue & ~i_is_end_reached;
  assign o_counter_clear = state == CLEAR;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CLEAR : IDLE;
      CLEAR:   state_nxt = RUN;
      RUN:     state_nxt = (hs && o_last) ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      issued_all    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      issued_all    <= state == CLEAR ? 1'b0 : issued_all | (issue & i_is_end_reached);
      inflight      <= issue;
      inflight_last <= issue & i_is_end_reached;
    end
  end
  skid_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (inflight),
    .pop    (hs),
    .din    ({inflight_last, i_rd_data}),
    .dout   ({o_last, o_data}),
    .count  (count)
  );
endmodule

// File: tb/tb_feature_fetcher.sv
// tb_feature_fetcher: table-driven passes with random data and ready, checked against a stream scoreboard
module tb_feature_fetcher;
  logic clk = 0, reset_n, start, i_ready;
  logic o_counter_clear, o_trigger_compare, i_is_end_reached, o_rd_en, o_valid, o_last, o_busy, o_done;
  logic [11:0] i_address, o_rd_address;
  logic [7:0] i_rd_data, o_data;
  logic [7:0] mem [4096];
  int max_size;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  feature_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .o_counter_clear(o_counter_clear), .o_trigger_compare(o_trigger_compare),
    .i_address(i_address), .i_is_end_reached(i_is_end_reached),
    .o_rd_en(o_rd_en), .o_rd_address(o_rd_address), .i_rd_data(i_rd_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  always_ff @(posedge clk) begin
    if (o_counter_clear) i_address <= '0;
    else if (o_trigger_compare) i_address <= i_address + 12'd1;
    if (o_rd_en) i_rd_data <= mem[o_rd_address];
  end
  assign i_is_end_reached = i_address == 12'(max_size - 1);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int n; int mode; int exp_first; int exp_trig;} vec_t;

  // mode: 0 ready high, 1 ready 1010 with a 5-cycle stall, 2 random ready, 3 ready high with start pulsed in RUN
  task automatic run_pass(input vec_t v, input int rst_at);
    int widx = 0, issue_idx = 0, trig = 0, clears = 0, first = -1, last_hs = -1, done_c = -1;
    int occ = 0, rd1 = 0, rd2 = 0, hs1 = 0, hs;
    logic [7:0] pdata = 0;
    logic plast = 0, pstall = 0;
    for (int i = 0; i < v.n; i++) mem[i] = 8'($urandom);
    max_size = v.n;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      i_ready = (v.mode == 1) ? ((c >= 8 && c < 13) ? 1'b0 : (c % 2 == 0)) :
                (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = v.mode == 3 && c == 6;
      occ = occ + rd2 - hs1;
      if (rst_at >= 0 && widx == rst_at) begin
        reset_n = 0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_data", o_data, 0);
        chk("rst_trig", o_trigger_compare, 0);
        @(negedge clk);
        reset_n = 1;
        start = 0;
        return;
      end
      #1;
      hs = o_valid && i_ready;
      chk("valid_vs_occ", o_valid, occ != 0);
      if (pstall) begin
        chk("stall_data", o_data, pdata);
        chk("stall_last", o_last, plast);
      end
      if (o_counter_clear) clears++;
      if (o_trigger_compare) trig++;
      if (o_rd_en) begin
        chk("rd_addr", o_rd_address, issue_idx);
        chk("credit", occ + rd1 - hs < 2, 1);
        issue_idx++;
      end
      if (o_valid && first < 0) first = c;
      if (hs) begin
        chk("data", o_data, mem[widx]);
        chk("last", o_last, widx == v.n - 1);
        if (v.mode == 0 || v.mode == 3) chk("cadence", c, 3 + widx);
        if (widx == v.n - 1) last_hs = c;
        widx++;
      end
      if (o_done) done_c = c;
      pstall = o_valid && !i_ready;
      pdata = o_data;
      plast = o_last;
      rd2 = rd1;
      rd1 = o_rd_en;
      hs1 = hs;
      @(negedge clk);
    end
    start = 0;
    #1;
    chk("done_seen", done_c >= 0, 1);
    chk("done_after_last", done_c, last_hs + 1);
    chk("words", widx, v.n);
    chk("triggers", trig, v.exp_trig);
    chk("clears", clears, 1);
    chk("first_valid", first, v.exp_first);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_valid, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{10, 0, 3, 9};
    vecs[1] = '{1, 0, 3, 0};
    vecs[2] = '{10, 1, 3, 9};
    vecs[3] = '{10, 3, 3, 9};
    vecs[4] = '{10, 0, 3, 9};
    vecs[5] = '{7, 2, 3, 6};
    vecs[6] = '{3, 2, 3, 2};
    vecs[7] = '{2, 0, 3, 1};
    reset_n = 0; start = 0; i_ready = 0; max_size = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_rd_en", o_rd_en, 0);
    chk("reset_clear", o_counter_clear, 0);
    chk("reset_done", o_done, 0);
    reset_n = 1;
    foreach (vecs[i]) run_pass(vecs[i], -1);
    run_pass('{10, 0, 3, 9}, 4);
    run_pass('{10, 0, 3, 9}, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
